// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state type, decode field positions and FIFO entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam int INSTR_W = 32;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int SH_MSB = 10;
    localparam int SH_LSB = 6;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} fetch entries with flush and occupancy count.
// Ports: clk, rst, flush, push, push_data, pop, head, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/gnt/rvalid imem fetch into a FIFO, decoded head to ID.
// Ports: imem_*, redirect_*, id_* handshake, decode fields; perf_* with FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [5:0]  Op_code,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   pc;
    logic [31:0]   pc_req;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          has_space;
    logic          granted;

    // Only IDLE launches a fetch and only one is ever in flight,
    // so checking here reserves the slot for the pending response.
    assign has_space = count < CW'(FIFO_DEPTH);
    assign granted   = (state == REQ) && imem_gnt;
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = id_valid && id_ready;
    assign push_data = '{pc: pc_req, instr: imem_rdata};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!redirect_valid && has_space) state_nx = REQ;
            REQ: begin
                if (imem_gnt)
                    state_nx = redirect_valid ? DROP : WAIT;
                else if (redirect_valid)
                    state_nx = IDLE;
            end
            WAIT: begin
                if (imem_rvalid)
                    state_nx = IDLE;
                else if (redirect_valid)
                    state_nx = DROP;
            end
            // A redirect here still waits out the killed response.
            DROP: if (imem_rvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            pc_req <= RESET_PC;
        end else begin
            state <= state_nx;
            if (redirect_valid)
                pc <= redirect_pc & ~32'h3;
            else if (granted)
                pc <= pc + PC_STEP;
            if (granted)
                pc_req <= pc;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign id_valid = (count != '0);
    assign id_instr = id_valid ? head.instr : '0;
    assign id_pc    = id_valid ? head.pc : '0;
    assign Op_code  = id_instr[OP_MSB:OP_LSB];
    assign Rs       = id_instr[RS_MSB:RS_LSB];
    assign Rt       = id_instr[RT_MSB:RT_LSB];
    assign Shamt    = id_instr[SH_MSB:SH_LSB];
    assign Funct    = id_instr[FN_MSB:FN_LSB];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (!id_valid && state != DROP)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// imem timing, backpressure and redirects against a PC-stream reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  Op_code;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Shamt;
    logic [5:0]  Funct;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
    logic [31:0] perf_stall_cycles2;
    logic [31:0] perf_flush_count2;
`endif

    // second instance: wrap-around reset PC, always-grant memory
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2 = 1'b0;
    logic        vld2;
    logic [31:0] instr2, pc2;
    logic [5:0]  op2, fn2;
    logic [4:0]  rs2, rt2, sh2;
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc),
        .Op_code(Op_code), .Rs(Rs), .Rt(Rt),
        .Shamt(Shamt), .Funct(Funct)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count(perf_flush_count)
`endif
    );

    assign gnt2 = req2;

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(gnt2), .imem_rvalid(rvalid2),
        .imem_rdata(32'h1234_5678),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(vld2), .id_ready(1'b1),
        .id_instr(instr2), .id_pc(pc2),
        .Op_code(op2), .Rs(rs2), .Rt(rt2),
        .Shamt(sh2), .Funct(fn2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cycles(perf_stall_cycles2),
        .perf_flush_count(perf_flush_count2)
`endif
    );

    always @(posedge clk) begin
        rvalid2 <= req2 && gnt2;
        if (req2 && gnt2)
            q2.push_back(addr2);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory responder knobs and state
    int          gnt_pct = 100;
    int          lat_fix = 1;
    bit          fixed_en = 0;
    logic [31:0] fixed_word = '0;
    bit          junk_next = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    // reference model: the consumed stream and the fetch stream
    // are both consecutive words from the last redirect target
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_fetch = '0;
    bit          prev_rd = 0;
    bit          hold = 0;
    logic [31:0] hold_addr = '0;
    int          grants = 0;
    int          pops = 0;
    bit          last_gt = 0;
    logic [31:0] last_gnt_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (fixed_en)
            return fixed_word;
        return {a[15:0] ^ 16'hA5C3, a[31:16] + a[9:2] + 16'h1357};
    endfunction

    // Called at a negedge: sample, check, drive inputs, advance a cycle.
    task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc);
        bit          rv;
        bit          gt;
        logic [31:0] ra;
        logic [31:0] w;
        rv = 0;
        gt = 0;
        ra = pend_addr;
        if (prev_rd)
            check("flush_vld", {31'b0, id_valid}, 32'd0);
        if (hold) begin
            check("req_hold", {31'b0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, hold_addr);
        end
        if (!id_valid)
            check("empty_instr", id_instr, 32'd0);
        if (pend) begin
            if (pend_cnt == 0) begin
                rv = 1;
                pend = 0;
            end else begin
                pend_cnt--;
            end
        end
        if (imem_req && ($urandom_range(99) < gnt_pct))
            gt = 1;
        if (id_valid && rdy) begin
            w = mem_word(exp_pc);
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, w);
            check("op", {26'b0, Op_code}, {26'b0, w[31:26]});
            check("rs", {27'b0, Rs}, {27'b0, w[25:21]});
            check("rt", {27'b0, Rt}, {27'b0, w[20:16]});
            check("sh", {27'b0, Shamt}, {27'b0, w[10:6]});
            check("fn", {26'b0, Funct}, {26'b0, w[5:0]});
            exp_pc += 32'd4;
            pops++;
        end
        last_gt = gt;
        if (gt) begin
            check("fetch_addr", imem_addr, exp_fetch);
            last_gnt_addr = imem_addr;
            pend = 1;
            pend_addr = exp_fetch;
            pend_cnt = (lat_fix != 0 ? lat_fix : $urandom_range(3, 1)) - 1;
            exp_fetch += 32'd4;
            grants++;
        end
        if (rd) begin
            exp_pc = rpc & ~32'h3;
            exp_fetch = exp_pc;
        end
        prev_rd = rd;
        hold = imem_req && !gt && !rd;
        hold_addr = imem_addr;
        imem_gnt = gt;
        imem_rvalid = rv;
        if (rv && junk_next) begin
            imem_rdata = 32'hDEAD_BEEF;
            junk_next = 0;
        end else if (rv) begin
            imem_rdata = mem_word(ra);
        end else begin
            imem_rdata = $urandom();
        end
        id_ready = rdy;
        redirect_valid = rd;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_gnt = 0;
        imem_rvalid = 0;
        redirect_valid = 0;
        id_ready = 0;
        @(negedge clk);
        @(negedge clk);
        pend = 0;
        exp_pc = '0;
        exp_fetch = '0;
        prev_rd = 0;
        hold = 0;
        grants = 0;
        pops = 0;
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        // reset state
        @(negedge clk);
        #1;
        check("rst_vld", {31'b0, id_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", id_instr, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_op", {26'b0, Op_code}, 32'd0);
        check("rst_fn", {26'b0, Funct}, 32'd0);

        // add instruction stream 0,4,8
        fixed_en = 1;
        fixed_word = 32'h0000_1820;
        gnt_pct = 100;
        lat_fix = 1;
        apply_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("rv_to_vld", {31'b0, id_valid}, 32'd1);
        guard = 0;
        while (pops < 3 && guard < 50) begin
            cycle(1, 0, 0);
            guard++;
        end
        check("add_pops", pops, 3);
        fixed_en = 0;

        // wrapping reset PC instance
        check("wrap_n", {31'b0, q2.size() >= 2}, 32'd1);
        if (q2.size() >= 2) begin
            check("wrap_a0", q2[0], 32'hFFFF_FFFC);
            check("wrap_a1", q2[1], 32'h0000_0000);
        end

        // backpressure fills FIFO, then resumes
        apply_reset();
        repeat (30) cycle(0, 0, 0);
        check("bp_grants", grants, 2);
        check("bp_req", {31'b0, imem_req}, 32'd0);
        check("bp_vld", {31'b0, id_valid}, 32'd1);
        guard = 0;
        while (grants < 3 && guard < 20) begin
            cycle(1, 0, 0);
            guard++;
        end
        check("bp_resume", grants, 3);
        check("bp_addr8", last_gnt_addr, 32'h8);

        // redirect while waiting for the response
        lat_fix = 2;
        apply_reset();
        guard = 0;
        cycle(1, 0, 0);
        while (!last_gt && guard < 20) begin
            cycle(1, 0, 0);
            guard++;
        end
        cycle(1, 1, 32'h0000_0043);
        junk_next = 1;
        guard = 0;
        while (!id_valid && guard < 30) begin
            cycle(1, 0, 0);
            guard++;
        end
        check("wait_redir_gnt", last_gnt_addr, 32'h40);
        check("wait_redir_pc", id_pc, 32'h40);

        // redirect in the same cycle as the grant
        lat_fix = 1;
        apply_reset();
        junk_next = 1;
        cycle(1, 1, 32'h0000_0200);
        cycle(1, 0, 0);
        check("drop_nopush", {31'b0, id_valid}, 32'd0);
        guard = 0;
        while (!id_valid && guard < 30) begin
            cycle(1, 0, 0);
            guard++;
        end
        check("drop_pc", id_pc, 32'h200);

        // async reset in WAIT with one entry buffered
        lat_fix = 3;
        apply_reset();
        guard = 0;
        while (grants < 2 && guard < 40) begin
            cycle(0, 0, 0);
            guard++;
        end
        check("mid_pre_vld", {31'b0, id_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_vld", {31'b0, id_valid}, 32'd0);
        check("mid_req", {31'b0, imem_req}, 32'd0);
        check("mid_pc", id_pc, 32'd0);
        apply_reset();

        // randomized traffic
        gnt_pct = 60;
        lat_fix = 0;
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(99) < 70, $urandom_range(99) < 4, $urandom());
        end
        check("rand_live", {31'b0, pops > 100}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
